// File: rtl/afe_l2_regfile_pkg.sv
// Shared register map, CFG bit positions and per-channel config type for afe_l2_regfile.
package afe_l2_regfile_pkg;

  localparam logic [2:0] REG_SADDR    = 3'd0;
  localparam logic [2:0] REG_SIZE     = 3'd1;
  localparam logic [2:0] REG_CFG      = 3'd2;
  localparam logic [2:0] REG_CURRADDR = 3'd3;
  localparam logic [2:0] REG_BYTELEFT = 3'd4;

  localparam logic [2:0] REG_EVT_STATUS = 3'd0;
  localparam logic [2:0] REG_IRQ_MASK   = 3'd1;
  localparam logic [2:0] REG_FLAG_CNT   = 3'd2;
  localparam logic [2:0] REG_INFO       = 3'd3;

  localparam int CFG_CONT_BIT  = 0;
  localparam int CFG_DSIZE_LSB = 1;
  localparam int CFG_EN_BIT    = 4;
  localparam int CFG_CLR_BIT   = 5;
  localparam int CFG_PEND_BIT  = 6;

  localparam logic [1:0] DSIZE_RST = 2'b10;

  // Shadow start address/size are kept word-wide so reads return them directly.
  typedef struct packed {
    logic [31:0] startaddr;
    logic [31:0] size;
    logic [1:0]  datasize;
    logic        continuous;
  } chan_cfg_t;

  // The all-ones channel index selects the generic block.
  function automatic int gen_idx(input int addr_width);
    return (1 << (addr_width - 3)) - 1;
  endfunction

  function automatic logic [31:0] word_mask(input int width);
    logic [63:0] full;
    full = (64'd1 << width) - 64'd1;
    return full[31:0] & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/afe_l2_chan_regs.sv
// One L2 channel: shadow start/size with pending flag, active copy, CFG fields and en/clr pulses.
module afe_l2_chan_regs
  import afe_l2_regfile_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int L2_TRANS_SIZE  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      we_i,
  input  logic [2:0]                sel_i,
  input  logic [31:0]               wdata_i,
  input  logic                      done_i,
  output chan_cfg_t                 cfg_o,
  output logic                      pending_o,
  output logic [L2_AWIDTH_NOAL-1:0] startaddr_o,
  output logic [L2_TRANS_SIZE-1:0]  size_o,
  output logic                      en_o,
  output logic                      clr_o
);

  localparam logic [31:0] SADDR_MASK = word_mask(L2_AWIDTH_NOAL);
  localparam logic [31:0] SIZE_MASK  = word_mask(L2_TRANS_SIZE);

  chan_cfg_t                 cfg_reg;
  logic                      pending_reg;
  logic [L2_AWIDTH_NOAL-1:0] startaddr_reg;
  logic [L2_TRANS_SIZE-1:0]  size_reg;
  logic                      en_reg;
  logic                      clr_reg;

  logic cfg_wr;
  logic load_active;

  assign cfg_wr      = we_i && (sel_i == REG_CFG);
  assign load_active = (done_i && cfg_reg.continuous && pending_reg) ||
                       (cfg_wr && wdata_i[CFG_EN_BIT]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_reg       <= '{startaddr: '0, size: '0, datasize: DSIZE_RST, continuous: 1'b0};
      pending_reg   <= 1'b0;
      startaddr_reg <= '0;
      size_reg      <= '0;
      en_reg        <= 1'b0;
      clr_reg       <= 1'b0;
    end else begin
      en_reg  <= cfg_wr && wdata_i[CFG_EN_BIT];
      clr_reg <= cfg_wr && wdata_i[CFG_CLR_BIT];
      // The copy takes the pre-edge shadow; a same-edge shadow write re-arms pending below.
      if (load_active) begin
        startaddr_reg <= cfg_reg.startaddr[L2_AWIDTH_NOAL-1:0];
        size_reg      <= cfg_reg.size[L2_TRANS_SIZE-1:0];
        pending_reg   <= 1'b0;
      end
      if (we_i && (sel_i == REG_SADDR)) begin
        cfg_reg.startaddr <= wdata_i & SADDR_MASK;
        pending_reg       <= 1'b1;
      end
      if (we_i && (sel_i == REG_SIZE)) begin
        cfg_reg.size <= wdata_i & SIZE_MASK;
        pending_reg  <= 1'b1;
      end
      if (cfg_wr) begin
        cfg_reg.continuous <= wdata_i[CFG_CONT_BIT];
        cfg_reg.datasize   <= wdata_i[CFG_DSIZE_LSB +: 2];
      end
    end
  end

  assign cfg_o       = cfg_reg;
  assign pending_o   = pending_reg;
  assign startaddr_o = startaddr_reg;
  assign size_o      = size_reg;
  assign en_o        = en_reg;
  assign clr_o       = clr_reg;

endmodule

// File: rtl/afe_l2_regfile.sv
// AFE L2 config register file: registered reads, per-channel double-buffered DMA config, W1C events + IRQ.
// Optional AFE_L2_REGFILE_ERR_RESP_EN adds cfg_err_o for unmapped/read-only accesses.
module afe_l2_regfile
  import afe_l2_regfile_pkg::*;
#(
  parameter int NUM_CHS        = 8,
  parameter int ADDR_WIDTH     = 11,
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int L2_TRANS_SIZE  = 16,
  parameter int FLAG_CNT_WIDTH = 8
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     cfg_valid_i,
  input  logic                                     cfg_rwn_i,
  input  logic [ADDR_WIDTH-1:0]                    cfg_addr_i,
  input  logic [31:0]                              cfg_wdata_i,
  output logic                                     cfg_ready_o,
  output logic [31:0]                              cfg_rdata_o,
  output logic                                     cfg_rvalid_o,
  output logic [NUM_CHS-1:0][L2_AWIDTH_NOAL-1:0]   cfg_l2_startaddr_o,
  output logic [NUM_CHS-1:0][L2_TRANS_SIZE-1:0]    cfg_l2_size_o,
  output logic [NUM_CHS-1:0][1:0]                  cfg_l2_datasize_o,
  output logic [NUM_CHS-1:0]                       cfg_l2_continuous_o,
  output logic [NUM_CHS-1:0]                       cfg_l2_en_o,
  output logic [NUM_CHS-1:0]                       cfg_l2_clr_o,
  input  logic [NUM_CHS-1:0]                       cfg_l2_en_i,
  input  logic [NUM_CHS-1:0]                       cfg_l2_done_i,
  input  logic [NUM_CHS-1:0][L2_AWIDTH_NOAL-1:0]   cfg_l2_curr_addr_i,
  input  logic [NUM_CHS-1:0][L2_TRANS_SIZE-1:0]    cfg_l2_bytes_left_i,
  input  logic [FLAG_CNT_WIDTH-1:0]                cfg_flag_cnt_i,
  output logic                                     cfg_flag_clr_o,
  output logic                                     irq_o
`ifdef AFE_L2_REGFILE_ERR_RESP_EN
  ,
  output logic                                     cfg_err_o
`endif
);

  localparam int             CW      = ADDR_WIDTH - 3;
  localparam logic [CW-1:0]  GEN_IDX = CW'(gen_idx(ADDR_WIDTH));

  logic              rvalid_reg;
  logic [31:0]       rdata_reg;
  logic              flag_clr_reg;
  logic              irq_reg;
  logic [NUM_CHS-1:0] evt_status_reg;
  logic [NUM_CHS-1:0] irq_mask_reg;
  logic [31:0]       rdata_next;

  logic [CW-1:0]     ch_idx;
  logic [2:0]        reg_sel;
  logic              rd_acc, wr_acc, is_gen, is_ch;
  logic [NUM_CHS-1:0] evt_clr;
  logic [NUM_CHS-1:0] chan_we;
  logic [NUM_CHS-1:0] chan_pending;
  chan_cfg_t         chan_cfg [NUM_CHS];

  // Ready drops for the response cycle, so reads run at one per two cycles.
  assign cfg_ready_o = ~rvalid_reg;
  assign rd_acc      = cfg_valid_i && cfg_ready_o && cfg_rwn_i;
  assign wr_acc      = cfg_valid_i && cfg_ready_o && !cfg_rwn_i;
  assign ch_idx      = cfg_addr_i[ADDR_WIDTH-1:3];
  assign reg_sel     = cfg_addr_i[2:0];
  assign is_gen      = (ch_idx == GEN_IDX);
  assign is_ch       = (ch_idx < CW'(NUM_CHS));
  assign evt_clr     = (wr_acc && is_gen && (reg_sel == REG_EVT_STATUS)) ?
                       cfg_wdata_i[NUM_CHS-1:0] : '0;

  genvar gi;
  for (gi = 0; gi < NUM_CHS; gi++) begin : g_chan
    assign chan_we[gi] = wr_acc && is_ch && (ch_idx == CW'(gi));

    afe_l2_chan_regs #(
      .L2_AWIDTH_NOAL(L2_AWIDTH_NOAL),
      .L2_TRANS_SIZE (L2_TRANS_SIZE)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .we_i       (chan_we[gi]),
      .sel_i      (reg_sel),
      .wdata_i    (cfg_wdata_i),
      .done_i     (cfg_l2_done_i[gi]),
      .cfg_o      (chan_cfg[gi]),
      .pending_o  (chan_pending[gi]),
      .startaddr_o(cfg_l2_startaddr_o[gi]),
      .size_o     (cfg_l2_size_o[gi]),
      .en_o       (cfg_l2_en_o[gi]),
      .clr_o      (cfg_l2_clr_o[gi])
    );

    assign cfg_l2_datasize_o[gi]   = chan_cfg[gi].datasize;
    assign cfg_l2_continuous_o[gi] = chan_cfg[gi].continuous;
  end

  always_comb begin
    rdata_next = '0;
    if (is_gen) begin
      case (reg_sel)
        REG_EVT_STATUS: rdata_next = 32'(evt_status_reg);
        REG_IRQ_MASK:   rdata_next = 32'(irq_mask_reg);
        REG_FLAG_CNT:   rdata_next = 32'(cfg_flag_cnt_i);
        REG_INFO:       rdata_next = {16'(NUM_CHS), 8'(ADDR_WIDTH), 8'h02};
        default:        rdata_next = '0;
      endcase
    end else if (is_ch) begin
      for (int c = 0; c < NUM_CHS; c++) begin
        if (ch_idx == CW'(c)) begin
          case (reg_sel)
            REG_SADDR: rdata_next = chan_cfg[c].startaddr;
            REG_SIZE:  rdata_next = chan_cfg[c].size;
            REG_CFG: begin
              rdata_next[CFG_CONT_BIT]       = chan_cfg[c].continuous;
              rdata_next[CFG_DSIZE_LSB +: 2] = chan_cfg[c].datasize;
              rdata_next[CFG_EN_BIT]         = cfg_l2_en_i[c];
              rdata_next[CFG_PEND_BIT]       = chan_pending[c];
            end
            REG_CURRADDR: rdata_next = 32'(cfg_l2_curr_addr_i[c]);
            REG_BYTELEFT: rdata_next = 32'(cfg_l2_bytes_left_i[c]);
            default:      rdata_next = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_reg     <= 1'b0;
      rdata_reg      <= '0;
      flag_clr_reg   <= 1'b0;
      irq_reg        <= 1'b0;
      evt_status_reg <= '0;
      irq_mask_reg   <= '0;
    end else begin
      rvalid_reg   <= rd_acc;
      rdata_reg    <= rd_acc ? rdata_next : '0;
      flag_clr_reg <= rd_acc && is_gen && (reg_sel == REG_FLAG_CNT);
      irq_reg      <= |(evt_status_reg & irq_mask_reg);
      // A done pulse wins over a same-edge write-1-to-clear.
      evt_status_reg <= (evt_status_reg & ~evt_clr) | cfg_l2_done_i;
      if (wr_acc && is_gen && (reg_sel == REG_IRQ_MASK)) begin
        irq_mask_reg <= cfg_wdata_i[NUM_CHS-1:0];
      end
    end
  end

  assign cfg_rvalid_o   = rvalid_reg;
  assign cfg_rdata_o    = rdata_reg;
  assign cfg_flag_clr_o = flag_clr_reg;
  assign irq_o          = irq_reg;

`ifdef AFE_L2_REGFILE_ERR_RESP_EN
  logic err_reg;
  logic rd_mapped, wr_mapped;

  assign rd_mapped = (is_gen && (reg_sel <= REG_INFO)) || (is_ch && (reg_sel <= REG_BYTELEFT));
  assign wr_mapped = (is_gen && (reg_sel <= REG_IRQ_MASK)) || (is_ch && (reg_sel <= REG_CFG));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= (rd_acc && !rd_mapped) || (wr_acc && !wr_mapped);
    end
  end

  assign cfg_err_o = err_reg;
`endif

endmodule

// File: tb/tb_afe_l2_regfile.sv
// Directed + random bench for afe_l2_regfile against an array-based register model.
module tb_afe_l2_regfile;
  localparam int NCH = 8;
  localparam int L2A = 12;
  localparam int L2S = 16;
  localparam int GEN = 255;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic                      cfg_valid_i = 1'b0;
  logic                      cfg_rwn_i = 1'b0;
  logic [10:0]               cfg_addr_i = '0;
  logic [31:0]               cfg_wdata_i = '0;
  logic                      cfg_ready_o;
  logic [31:0]               cfg_rdata_o;
  logic                      cfg_rvalid_o;
  logic [NCH-1:0][L2A-1:0]   cfg_l2_startaddr_o;
  logic [NCH-1:0][L2S-1:0]   cfg_l2_size_o;
  logic [NCH-1:0][1:0]       cfg_l2_datasize_o;
  logic [NCH-1:0]            cfg_l2_continuous_o;
  logic [NCH-1:0]            cfg_l2_en_o;
  logic [NCH-1:0]            cfg_l2_clr_o;
  logic [NCH-1:0]            cfg_l2_en_i = '0;
  logic [NCH-1:0]            cfg_l2_done_i = '0;
  logic [NCH-1:0][L2A-1:0]   cfg_l2_curr_addr_i = '0;
  logic [NCH-1:0][L2S-1:0]   cfg_l2_bytes_left_i = '0;
  logic [7:0]                cfg_flag_cnt_i = '0;
  logic                      cfg_flag_clr_o;
  logic                      irq_o;
`ifdef AFE_L2_REGFILE_ERR_RESP_EN
  logic                      cfg_err_o;
`endif

  afe_l2_regfile dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_valid_i(cfg_valid_i), .cfg_rwn_i(cfg_rwn_i), .cfg_addr_i(cfg_addr_i),
    .cfg_wdata_i(cfg_wdata_i), .cfg_ready_o(cfg_ready_o), .cfg_rdata_o(cfg_rdata_o),
    .cfg_rvalid_o(cfg_rvalid_o), .cfg_l2_startaddr_o(cfg_l2_startaddr_o),
    .cfg_l2_size_o(cfg_l2_size_o), .cfg_l2_datasize_o(cfg_l2_datasize_o),
    .cfg_l2_continuous_o(cfg_l2_continuous_o), .cfg_l2_en_o(cfg_l2_en_o),
    .cfg_l2_clr_o(cfg_l2_clr_o), .cfg_l2_en_i(cfg_l2_en_i), .cfg_l2_done_i(cfg_l2_done_i),
    .cfg_l2_curr_addr_i(cfg_l2_curr_addr_i), .cfg_l2_bytes_left_i(cfg_l2_bytes_left_i),
    .cfg_flag_cnt_i(cfg_flag_cnt_i), .cfg_flag_clr_o(cfg_flag_clr_o), .irq_o(irq_o)
`ifdef AFE_L2_REGFILE_ERR_RESP_EN
    , .cfg_err_o(cfg_err_o)
`endif
  );

  // Reference model state
  logic [31:0]    m_sh_sa [NCH];
  logic [31:0]    m_sh_sz [NCH];
  logic [31:0]    m_act_sa[NCH];
  logic [31:0]    m_act_sz[NCH];
  logic           m_pend  [NCH];
  logic           m_cont  [NCH];
  logic [1:0]     m_ds    [NCH];
  logic [NCH-1:0] m_evt, m_mask, m_en, m_clr;
  logic           m_rvalid, m_flag_clr, m_irq, m_err;
  logic [31:0]    m_rdata;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_sh_sa[c] = '0; m_sh_sz[c] = '0; m_act_sa[c] = '0; m_act_sz[c] = '0;
      m_pend[c] = 1'b0; m_cont[c] = 1'b0; m_ds[c] = 2'b10;
    end
    m_evt = '0; m_mask = '0; m_en = '0; m_clr = '0;
    m_rvalid = 1'b0; m_flag_clr = 1'b0; m_irq = 1'b0; m_err = 1'b0; m_rdata = '0;
  endtask

  function automatic logic [10:0] adr(input int ch, input int sel);
    return {ch[7:0], sel[2:0]};
  endfunction

  function automatic logic [31:0] exp_read(input int ch, input int sel);
    logic [31:0] r;
    r = '0;
    if (ch == GEN) begin
      case (sel)
        0: r = 32'(m_evt);
        1: r = 32'(m_mask);
        2: r = 32'(cfg_flag_cnt_i);
        3: r = 32'h0008_0B02;
        default: r = '0;
      endcase
    end else if (ch < NCH) begin
      case (sel)
        0: r = m_sh_sa[ch];
        1: r = m_sh_sz[ch];
        2: r = {25'd0, m_pend[ch], 1'b0, cfg_l2_en_i[ch], 1'b0, m_ds[ch], m_cont[ch]};
        3: r = 32'(cfg_l2_curr_addr_i[ch]);
        4: r = 32'(cfg_l2_bytes_left_i[ch]);
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  task automatic check_all();
    logic [NCH-1:0][L2A-1:0] e_sa;
    logic [NCH-1:0][L2S-1:0] e_sz;
    logic [NCH-1:0][1:0]     e_ds;
    logic [NCH-1:0]          e_ct;
    for (int c = 0; c < NCH; c++) begin
      e_sa[c] = m_act_sa[c][L2A-1:0];
      e_sz[c] = m_act_sz[c][L2S-1:0];
      e_ds[c] = m_ds[c];
      e_ct[c] = m_cont[c];
    end
    chk("ready", 128'(cfg_ready_o), 128'(!m_rvalid));
    chk("rvalid", 128'(cfg_rvalid_o), 128'(m_rvalid));
    chk("rdata", 128'(cfg_rdata_o), 128'(m_rdata));
    chk("flag_clr", 128'(cfg_flag_clr_o), 128'(m_flag_clr));
    chk("l2_en", 128'(cfg_l2_en_o), 128'(m_en));
    chk("l2_clr", 128'(cfg_l2_clr_o), 128'(m_clr));
    chk("irq", 128'(irq_o), 128'(m_irq));
    chk("startaddr", 128'(cfg_l2_startaddr_o), 128'(e_sa));
    chk("size", 128'(cfg_l2_size_o), 128'(e_sz));
    chk("datasize", 128'(cfg_l2_datasize_o), 128'(e_ds));
    chk("continuous", 128'(cfg_l2_continuous_o), 128'(e_ct));
`ifdef AFE_L2_REGFILE_ERR_RESP_EN
    chk("err", 128'(cfg_err_o), 128'(m_err));
`endif
  endtask

  // One clock: drive request/done, step the model by the register rules, compare everything.
  task automatic cycle(input bit v, input bit rwn, input logic [10:0] addr,
                       input logic [31:0] wd, input logic [NCH-1:0] done);
    int ch, sel;
    bit acc;
    logic [31:0] rv;
    ch = int'(addr[10:3]);
    sel = int'(addr[2:0]);
    cfg_valid_i = v; cfg_rwn_i = rwn; cfg_addr_i = addr; cfg_wdata_i = wd; cfg_l2_done_i = done;
    acc = v && !m_rvalid;
    rv = exp_read(ch, sel);
    @(posedge clk_i);
    #1;
    cfg_valid_i = 1'b0; cfg_l2_done_i = '0;
    m_irq = |(m_evt & m_mask);
    m_en = '0; m_clr = '0;
    for (int c = 0; c < NCH; c++) begin
      if (done[c] && m_cont[c] && m_pend[c]) begin
        m_act_sa[c] = m_sh_sa[c]; m_act_sz[c] = m_sh_sz[c]; m_pend[c] = 1'b0;
      end
    end
    if (acc && !rwn) begin
      if (ch < NCH) begin
        case (sel)
          0: begin m_sh_sa[ch] = wd & 32'h0000_0FFC; m_pend[ch] = 1'b1; end
          1: begin m_sh_sz[ch] = wd & 32'h0000_FFFC; m_pend[ch] = 1'b1; end
          2: begin
            m_cont[ch] = wd[0]; m_ds[ch] = wd[2:1]; m_clr[ch] = wd[5];
            if (wd[4]) begin
              m_act_sa[ch] = m_sh_sa[ch]; m_act_sz[ch] = m_sh_sz[ch];
              m_pend[ch] = 1'b0; m_en[ch] = 1'b1;
            end
          end
          default: ;
        endcase
      end else if (ch == GEN) begin
        if (sel == 0) m_evt = m_evt & ~wd[NCH-1:0];
        if (sel == 1) m_mask = wd[NCH-1:0];
      end
    end
    m_evt = m_evt | done;
    m_rvalid = acc && rwn;
    m_rdata = (acc && rwn) ? rv : 32'd0;
    m_flag_clr = acc && rwn && (ch == GEN) && (sel == 2);
    m_err = acc && (rwn ? !(((ch == GEN) && sel <= 3) || ((ch < NCH) && sel <= 4))
                        : !(((ch == GEN) && sel <= 1) || ((ch < NCH) && sel <= 2)));
    check_all();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic wr(input int ch, input int sel, input logic [31:0] d);
    cycle(1'b1, 1'b0, adr(ch, sel), d, '0);
  endtask

  task automatic rd(input int ch, input int sel, output logic [31:0] d);
    cycle(1'b1, 1'b1, adr(ch, sel), '0, '0);
    d = cfg_rdata_o;
    idle();
  endtask

  task automatic do_reset();
    rst_i = 1'b1; cfg_valid_i = 1'b0; cfg_l2_done_i = '0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
    check_all();
  endtask

  initial begin
    logic [31:0] d;
    int rch, rsel;
    model_reset();
    do_reset();

    // Reset CFG readback and response-cycle ready
    cycle(1'b1, 1'b1, adr(0, 2), '0, '0);
    chk("ch0_cfg_rd", 128'(cfg_rdata_o), 128'(32'h4));
    chk("rsp_ready_low", 128'(cfg_ready_o), 128'(1'b0));
    idle();

    // Shadow write, pending, then enable copies to active
    wr(3, 0, 32'h123);
    rd(3, 0, d);
    chk("ch3_shadow", 128'(d), 128'(32'h120));
    rd(3, 2, d);
    chk("ch3_pending", 128'(d[6]), 128'(1'b1));
    chk("ch3_active_before", 128'(cfg_l2_startaddr_o[3]), 128'(12'h0));
    wr(3, 2, 32'h14);
    chk("ch3_active_after", 128'(cfg_l2_startaddr_o[3]), 128'(12'h120));
    chk("ch3_en_pulse", 128'(cfg_l2_en_o), 128'(8'h08));
    idle();

    // Continuous reload on ch1
    cfg_l2_en_i = 8'h02;
    wr(1, 2, 32'h5);
    wr(1, 1, 32'h40);
    cycle(1'b0, 1'b0, '0, '0, 8'h02);
    chk("ch1_reload", 128'(cfg_l2_size_o[1]), 128'(16'h40));
    rd(1, 2, d);
    chk("ch1_pend_clr", 128'(d[6]), 128'(1'b0));
    wr(1, 1, 32'h44);
    cycle(1'b1, 1'b0, adr(1, 1), 32'h80, 8'h02);
    chk("ch1_same_edge_active", 128'(cfg_l2_size_o[1]), 128'(16'h44));
    rd(1, 1, d);
    chk("ch1_same_edge_shadow", 128'(d), 128'(32'h80));
    rd(1, 2, d);
    chk("ch1_same_edge_pend", 128'(d[6]), 128'(1'b1));

    // Events and IRQ
    wr(GEN, 1, 32'h05);
    cycle(1'b0, 1'b0, '0, '0, 8'h03);
    idle();
    chk("irq_set", 128'(irq_o), 128'(1'b1));
    rd(GEN, 0, d);
    chk("evt_status", 128'(d), 128'(32'h3));
    cycle(1'b1, 1'b0, adr(GEN, 0), 32'h1, 8'h01);
    rd(GEN, 0, d);
    chk("evt_set_wins", 128'(d), 128'(32'h3));
    wr(GEN, 0, 32'h3);
    idle();
    idle();
    chk("irq_clear", 128'(irq_o), 128'(1'b0));

    // Flag counter read-to-clear, then reset during the response
    cfg_flag_cnt_i = 8'h2A;
    cycle(1'b1, 1'b1, adr(GEN, 2), '0, '0);
    chk("flag_rd", 128'(cfg_rdata_o), 128'(32'h2A));
    chk("flag_clr_pulse", 128'(cfg_flag_clr_o), 128'(1'b1));
    idle();
    chk("flag_clr_once", 128'(cfg_flag_clr_o), 128'(1'b0));
    cycle(1'b1, 1'b1, adr(GEN, 2), '0, '0);
    rst_i = 1'b1;
    #1;
    chk("abort_rvalid", 128'(cfg_rvalid_o), 128'(1'b0));
    chk("abort_flag_clr", 128'(cfg_flag_clr_o), 128'(1'b0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
    check_all();

    // Unmapped accesses
    cycle(1'b1, 1'b1, adr(NCH, 0), '0, '0);
    chk("unmapped_rd", 128'(cfg_rdata_o), 128'(32'h0));
`ifdef AFE_L2_REGFILE_ERR_RESP_EN
    chk("unmapped_err", 128'(cfg_err_o), 128'(1'b1));
`endif
    idle();
    wr(2, 3, 32'hFFFF);
`ifdef AFE_L2_REGFILE_ERR_RESP_EN
    chk("ro_write_err", 128'(cfg_err_o), 128'(1'b1));
`endif
    rd(GEN, 3, d);
    chk("info", 128'(d), 128'(32'h0008_0B02));

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rch = $urandom_range(0, 11);
      if (rch >= 8 && rch <= 9) rch = GEN;
      else if (rch == 10) rch = $urandom_range(NCH, GEN - 1);
      else if (rch == 11) rch = NCH;
      rsel = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 4);
      if ($urandom_range(0, 7) == 0) cfg_l2_en_i = 8'($urandom);
      cfg_flag_cnt_i = 8'($urandom);
      for (int c = 0; c < NCH; c++) begin
        cfg_l2_curr_addr_i[c] = 12'($urandom);
        cfg_l2_bytes_left_i[c] = 16'($urandom);
      end
      cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), adr(rch, rsel),
            $urandom, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
